// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with word-by-word refill
// and a kseg1-style uncached bypass path.
module dcache_wt #(
  parameter int unsigned INDEX_BITS  = 6,
  parameter int unsigned OFFSET_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_data_w,
  output logic [31:0] cpu_data_r,
  output logic        cpu_stall,
  input  logic        no_dcache,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_w,
  input  logic [31:0] mem_data_r,
  input  logic        mem_ack
);

  localparam int unsigned TagBits  = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned Lines    = 1 << INDEX_BITS;
  localparam int unsigned WordBits = (OFFSET_BITS > 2) ? OFFSET_BITS - 2 : 1;
  localparam int unsigned Words    = 1 << (OFFSET_BITS - 2);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REFILL   = 2'd1;
  localparam logic [1:0] ST_WRITE    = 2'd2;
  localparam logic [1:0] ST_UNCACHED = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [WordBits-1:0] cnt_q, cnt_d;
  logic [Lines-1:0]    valid_q, valid_d;
  logic [TagBits-1:0]  tag_q  [Lines];
  logic [31:0]         data_q [Lines][Words];

  logic [INDEX_BITS-1:0] idx;
  logic [TagBits-1:0]    tag;
  logic [WordBits-1:0]   word;
  logic [31:0]           line_word;
  logic                  hit;
  logic [3:0]            be;
  logic [31:0]           merged;

  logic                data_we;
  logic [WordBits-1:0] data_word;
  logic [31:0]         data_wdata;
  logic                tag_we;

  assign idx       = cpu_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
  assign tag       = cpu_addr[31:OFFSET_BITS+INDEX_BITS];
  assign word      = WordBits'(cpu_addr[31:2]);
  assign line_word = data_q[idx][word];
  assign hit       = cpu_en & ~no_dcache & valid_q[idx] & (tag_q[idx] == tag);

  always_comb begin
    be = 4'b0000;
    unique case (cpu_size)
      2'd0:    be[cpu_addr[1:0]] = 1'b1;
      2'd1:    be = cpu_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    for (int b = 0; b < 4; b++) begin
      merged[8*b+:8] = be[b] ? cpu_data_w[8*b+:8] : line_word[8*b+:8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    cpu_stall  = 1'b0;
    cpu_data_r = 32'h0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'd0;
    mem_addr   = 32'h0;
    mem_data_w = 32'h0;
    data_we    = 1'b0;
    data_word  = word;
    data_wdata = merged;
    tag_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_en) begin
          if (no_dcache) begin
            cpu_stall = 1'b1;
            state_d   = ST_UNCACHED;
          end else if (cpu_we) begin
            cpu_stall = 1'b1;
            state_d   = ST_WRITE;
          end else if (hit) begin
            cpu_data_r = line_word;
          end else begin
            cpu_stall = 1'b1;
            cnt_d     = '0;
            state_d   = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        cpu_stall = 1'b1;
        mem_en    = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = {cpu_addr[31:OFFSET_BITS], cnt_q, 2'b00};
        if (mem_ack) begin
          data_we    = 1'b1;
          data_word  = cnt_q;
          data_wdata = mem_data_r;
          cnt_d      = cnt_q + WordBits'(1);
          // Line becomes valid only once its final word has landed.
          if (cnt_q == WordBits'(Words - 1)) begin
            valid_d[idx] = 1'b1;
            tag_we       = 1'b1;
            state_d      = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        mem_en     = 1'b1;
        mem_we     = 1'b1;
        mem_size   = cpu_size;
        mem_addr   = cpu_addr;
        mem_data_w = cpu_data_w;
        cpu_stall  = ~mem_ack;
        if (mem_ack) begin
          data_we = hit;
          state_d = ST_IDLE;
        end
      end
      default: begin
        mem_en     = 1'b1;
        mem_we     = cpu_we;
        mem_size   = cpu_size;
        mem_addr   = cpu_addr;
        mem_data_w = cpu_data_w;
        cpu_stall  = ~mem_ack;
        if (mem_ack) begin
          cpu_data_r = cpu_we ? 32'h0 : mem_data_r;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) data_q[idx][data_word] <= data_wdata;
    if (tag_we) tag_q[idx] <= tag;
  end

endmodule

// File: tb/tb_dcache_wt.sv
// Randomized bench for dcache_wt: a word-addressed memory model with configurable latency
// plus an abstract cache model that predicts data, stall length and memory traffic.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_we, no_dcache, cpu_stall;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_data_w, cpu_data_r;
  logic        mem_en, mem_we, mem_ack;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_data_w, mem_data_r;

  always #5 clk = ~clk;

  dcache_wt dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_en     (cpu_en),
    .cpu_we     (cpu_we),
    .cpu_size   (cpu_size),
    .cpu_addr   (cpu_addr),
    .cpu_data_w (cpu_data_w),
    .cpu_data_r (cpu_data_r),
    .cpu_stall  (cpu_stall),
    .no_dcache  (no_dcache),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_data_w (mem_data_w),
    .mem_data_r (mem_data_r),
    .mem_ack    (mem_ack)
  );

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned lat      = 1;
  int unsigned wait_cnt = 0;
  txn_t        log_q[$];
  logic [31:0] mem [int unsigned];

  // Abstract cache contents: 64 lines x 4 words, 22-bit tags.
  bit          ref_valid [64];
  logic [21:0] ref_tag   [64];
  logic [31:0] ref_data  [64][4];

  function automatic logic [31:0] mem_peek(input logic [31:0] a);
    int unsigned k = int'(a >> 2);
    if (mem.exists(k)) return mem[k];
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] nw,
                                             input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) begin
      if (size == 2'd2 || (size == 2'd1 && (b / 2) == int'(lo[1])) ||
          (size == 2'd0 && b == int'(lo)))
        r[8*b+:8] = nw[8*b+:8];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_en && !mem_ack) begin
        if (wait_cnt + 1 >= lat) begin
          txn_t t;
          t.we = mem_we; t.size = mem_size; t.addr = mem_addr; t.data = mem_data_w;
          log_q.push_back(t);
          if (mem_we)
            mem[int'(mem_addr >> 2)] = lane_merge(mem_peek(mem_addr), mem_data_w, mem_size,
                                                  mem_addr[1:0]);
          mem_data_r <= mem_peek(mem_addr);
          mem_ack    <= 1'b1;
          wait_cnt   <= 0;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end
    end
  end

  task automatic access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic nc, input string name);
    int          ix = int'(addr[9:4]);
    int          w  = int'(addr[3:2]);
    bit          hit = !nc && ref_valid[ix] && ref_tag[ix] == addr[31:10];
    txn_t        exp_q[$];
    txn_t        t;
    logic [31:0] exp_data = 32'h0;
    int          exp_cyc;
    bit          exp_mem_en;
    int          cyc = 0;
    bit          done = 0;
    logic [31:0] got = 32'h0;
    logic        got_mem_en = 1'b0;

    if (nc || we) begin
      t.we = we; t.size = size; t.addr = addr; t.data = wdata;
      exp_q.push_back(t);
      exp_cyc    = int'(lat) + 2;
      exp_mem_en = 1;
      if (!we) exp_data = mem_peek(addr);
    end else if (hit) begin
      exp_cyc    = 1;
      exp_mem_en = 0;
      exp_data   = ref_data[ix][w];
    end else begin
      for (int k = 0; k < 4; k++) begin
        t.we = 0; t.size = 2'd2; t.addr = {addr[31:4], 4'(k * 4)}; t.data = 32'h0;
        exp_q.push_back(t);
      end
      exp_cyc    = 2 + 4 * (int'(lat) + 1);
      exp_mem_en = 0;
      exp_data   = mem_peek(addr);
    end

    log_q.delete();
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_we = we; cpu_size = size; cpu_addr = addr;
    cpu_data_w = wdata; no_dcache = nc;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!cpu_stall) begin
        done = 1; got = cpu_data_r; got_mem_en = mem_en;
      end
    end
    @(posedge clk); #1;
    cpu_en = 1'b0;

    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: stall still high after %0d cycles, required low", name, cyc);
    end
    n_checks++;
    if (cyc != exp_cyc) begin
      n_fail++;
      $display("FAIL %s latency: got %0d cycles, required %0d", name, cyc, exp_cyc);
    end
    n_checks++;
    if (got_mem_en !== exp_mem_en) begin
      n_fail++;
      $display("FAIL %s mem_en at completion: got %b, required %b", name, got_mem_en,
               exp_mem_en);
    end
    if (!we) begin
      n_checks++;
      if (got !== exp_data) begin
        n_fail++;
        $display("FAIL %s data @%h: got %h, required %h", name, addr, got, exp_data);
      end
    end
    n_checks++;
    if (log_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s txn count: got %0d, required %0d", name, log_q.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (log_q[k].we !== exp_q[k].we || log_q[k].size !== exp_q[k].size ||
            log_q[k].addr !== exp_q[k].addr || (exp_q[k].we && log_q[k].data !== exp_q[k].data))
        begin
          n_fail++;
          $display("FAIL %s txn %0d: got we=%b sz=%0d a=%h d=%h, required we=%b sz=%0d a=%h d=%h",
                   name, k, log_q[k].we, log_q[k].size, log_q[k].addr, log_q[k].data,
                   exp_q[k].we, exp_q[k].size, exp_q[k].addr, exp_q[k].data);
        end
      end
    end

    // Update the abstract cache: store hits merge, load misses allocate, bypass is inert.
    if (!nc && we && hit) begin
      ref_data[ix][w] = lane_merge(ref_data[ix][w], wdata, size, addr[1:0]);
    end else if (!nc && !we && !hit) begin
      ref_valid[ix] = 1;
      ref_tag[ix]   = addr[31:10];
      for (int k = 0; k < 4; k++) ref_data[ix][k] = mem_peek({addr[31:4], 4'(k * 4)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0; cpu_size = 2'd0; cpu_addr = 32'h0;
    cpu_data_w = 32'h0; no_dcache = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 64; i++) ref_valid[i] = 0;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, mem_en, mem_we} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset ctrl: got stall/en/we=%b%b%b, required 000", cpu_stall, mem_en,
               mem_we);
    end
    n_checks++;
    if (mem_size !== 2'd0 || mem_addr !== 32'h0 || mem_data_w !== 32'h0) begin
      n_fail++;
      $display("FAIL reset mem bus: got sz=%0d a=%h d=%h, required 0/0/0", mem_size, mem_addr,
               mem_data_w);
    end
    n_checks++;
    if (cpu_data_r !== 32'h0) begin
      n_fail++;
      $display("FAIL reset data_r: got %h, required 00000000", cpu_data_r);
    end
  endtask

  task automatic test_refill();
    lat = 1;
    access(1'b0, 2'd2, 32'h0000_1004, 32'h0, 1'b0, "load_miss_1004");
    access(1'b0, 2'd2, 32'h0000_1008, 32'h0, 1'b0, "load_hit_1008");
  endtask

  task automatic test_store_hit();
    lat = 2;
    access(1'b1, 2'd0, 32'h0000_1005, 32'h0000_AB00, 1'b0, "store_byte_1005");
    access(1'b0, 2'd2, 32'h0000_1004, 32'h0, 1'b0, "load_after_store");
    n_checks++;
    if (ref_data[0][1][15:8] !== 8'hAB) begin
      n_fail++;
      $display("FAIL byte1 model after store: got %h, required ab", ref_data[0][1][15:8]);
    end
  endtask

  task automatic test_store_miss();
    lat = 1;
    access(1'b1, 2'd2, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0, "store_miss_2000");
    access(1'b0, 2'd2, 32'h0000_2000, 32'h0, 1'b0, "load_after_store_miss");
  endtask

  task automatic test_uncached();
    lat = 1;
    access(1'b0, 2'd2, 32'h0000_1004, 32'h0, 1'b0, "recache_1004");
    mem[int'(32'h0000_1004 >> 2)] = 32'h1234_5678;
    access(1'b0, 2'd2, 32'h0000_1004, 32'h0, 1'b1, "uncached_load_1004");
    access(1'b0, 2'd2, 32'h0000_1004, 32'h0, 1'b0, "stale_hit_1004");
  endtask

  task automatic test_alias();
    lat = 3;
    access(1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b0, "alias_1000");
    access(1'b0, 2'd2, 32'h0000_1400, 32'h0, 1'b0, "alias_1400");
    access(1'b0, 2'd2, 32'h0000_1000, 32'h0, 1'b0, "alias_1000_again");
  endtask

  task automatic test_reset_mid_refill();
    int g = 0;
    lat = 1;
    log_q.delete();
    @(posedge clk); #1;
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_size = 2'd2; cpu_addr = 32'h0000_3000; no_dcache = 1'b0;
    while (log_q.size() < 1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h0000_3004) begin
      n_fail++;
      $display("FAIL mid_refill word1: got en=%b a=%h, required en=1 a=00003004", mem_en,
               mem_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0; cpu_en = 1'b0;
    for (int i = 0; i < 64; i++) ref_valid[i] = 0;
    @(negedge clk);
    n_checks++;
    if (mem_en !== 1'b0 || cpu_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL after_rst: got en=%b stall=%b, required 0/0", mem_en, cpu_stall);
    end
    n_checks++;
    if (log_q.size() != 1) begin
      n_fail++;
      $display("FAIL abandoned txns: got %0d acked, required 1", log_q.size());
    end
    access(1'b0, 2'd2, 32'h0000_3000, 32'h0, 1'b0, "refill_after_rst");
  endtask

  task automatic test_random();
    int unsigned tags [4] = '{1, 2, 5, 7};
    int unsigned idxs [3] = '{0, 1, 63};
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [1:0]  s;
      logic        we;
      logic        nc;
      lat = $urandom_range(1, 3);
      a  = {22'(tags[$urandom_range(0, 3)]), 6'(idxs[$urandom_range(0, 2)]),
            2'($urandom_range(0, 3)), 2'b00};
      s  = 2'($urandom_range(0, 2));
      if (s == 2'd0) a[1:0] = 2'($urandom_range(0, 3));
      if (s == 2'd1) a[1] = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 9) < 4);
      nc = ($urandom_range(0, 9) < 2);
      access(we, we ? s : 2'd2, a, $urandom, nc, "random");
    end
  endtask

  initial begin
    test_reset();
    test_refill();
    test_store_hit();
    test_store_miss();
    test_uncached();
    test_alias();
    test_reset_mid_refill();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits directly downstream of the MMU's physical data bus and its no_dcache flag.
- Serves CPU loads and stores on the physical data bus.
- Refills lines word-by-word from a simple request/ack memory port.
- Bypasses the cache entirely for uncached (kseg1) accesses.

Parameters:
- INDEX_BITS, 6: log2 of number of lines (64 lines).
- OFFSET_BITS, 4: log2 of bytes per line (16 B, 4 words); must be at least 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cpu_en  in  1  CPU request valid.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_size  in  2  0 = byte, 1 = half, 2 = word.
- cpu_addr  in  32  physical address.
- cpu_data_w  in  32  store data, lane-aligned by the CPU.
- cpu_data_r  out  32  load data, word-aligned raw word.
- cpu_stall  out  1  CPU must hold its request while this is high.
- no_dcache  in  1  current request is uncached.
- mem_en  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_size  out  2  access size.
- mem_addr  out  32  memory address.
- mem_data_w  out  32  memory write data.
- mem_data_r  in  32  memory read data; valid when mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse.

Behaviour:
- Storage:
  - Per line: valid bit, tag of 32-INDEX_BITS-OFFSET_BITS bits, and 2^(OFFSET_BITS-2) data words.
  - Reads are asynchronous.
  - Reset clears every valid bit. Data and tag arrays need no reset.
- Address fields: index = addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS], word = addr[OFFSET_BITS-1:2].
- hit = cpu_en & ~no_dcache & valid[index] & (tag[index] == addr tag).
- States: IDLE, REFILL, WRITE, UNCACHED.
- Reset values:
  - state = IDLE.
  - mem_en = 0, mem_we = 0, mem_size = 0, mem_addr = 0, mem_data_w = 0.
  - cpu_stall = 0.
  - cpu_data_r = 0.
- IDLE:
  - cpu_en = 0: cpu_stall = 0.
  - Cached load hit: cpu_stall = 0 and cpu_data_r = line word in the same cycle (zero-latency hit).
  - Cached load miss: go to REFILL, cpu_stall = 1, refill counter = 0.
  - Cached store (hit or miss): go to WRITE, cpu_stall = 1.
  - no_dcache = 1 (load or store): go to UNCACHED, cpu_stall = 1.
- REFILL:
  - Issue word reads at {tag, index, counter, 2'b00} with mem_size = 2.
  - On each mem_ack, write mem_data_r into line word[counter] and increment the counter.
  - On the last ack, set valid and tag, then return to IDLE.
  - The next cycle is a hit: stall drops and the data is returned combinationally.
  - Load miss latency = 1 + words × (memory latency) + 1 cycles.
- WRITE:
  - Drive mem_we = 1, CPU size, CPU addr and data_w until mem_ack.
  - On the ack cycle, if the line hits, merge the enabled byte lanes into the cached word.
  - Lane enables:
    - Byte: lane addr[1:0].
    - Half: lanes {addr[1],0} and {addr[1],1}.
    - Word: all four lanes.
  - Miss: the cache is unchanged (no allocate).
  - In the ack cycle cpu_stall = 0, then go to IDLE.
- UNCACHED:
  - Single memory access with the CPU size and address; the cache is untouched.
  - On mem_ack (load): cpu_data_r = mem_data_r and cpu_stall = 0 in that cycle, then go to IDLE.
  - Stores complete the same way.
- Request hold rule: while cpu_stall = 1 the CPU holds cpu_* and no_dcache stable; the block samples them combinationally each cycle.
- mem_ack arriving in IDLE is ignored.
- rst asserted in any state:
  - Next cycle is IDLE with all valid bits cleared and mem_en = 0.
  - An in-flight memory transaction is abandoned.
  - A partially refilled line stays invalid.
- Refill counter wraps only by leaving REFILL. Index/tag aliasing replaces the old line.

Test Plan:
- After reset, load word 0x0000_1004 (cached):
  - Expect mem reads at 0x1000, 0x1004, 0x1008, 0x100C.
  - Stall high throughout the refill, then cpu_data_r = the word from 0x1004 with stall low.
  - A repeat load of 0x1008 has stall low on its first cycle with no mem_en.
- Store byte 0xAB at 0x1005 (hit, data_w 0x0000AB00):
  - Expect one mem write with size 0.
  - A later load of 0x1004 returns the original word with byte 1 = 0xAB and no refill.
- Store word to uncached-miss address 0x2000:
  - Expect mem write, stall released on ack.
  - A subsequent load of 0x2000 triggers a refill (no allocate on store).
- no_dcache = 1, load 0x1004 after it has been cached, memory now holds 0x12345678:
  - Expect a single mem read of size 2.
  - cpu_data_r = 0x12345678; the cached copy is unchanged.
- Addresses 0x1000 and 0x1400 (same index, default parameters):
  - The second load refills and evicts the first.
  - Reloading 0x1000 misses again.
- Assert rst during the second word of a refill:
  - mem_en = 0 next cycle.
  - The same load afterwards performs a full 4-word refill.
